sync_fifo_ctrl: RTL and testbench

Pointer and handshake controller that turns the team's 2-port synchronous memory (sync_mem) into a FIFO. It sits directly upstream of sync_mem and drives both ports: port 0 is write-only for pushes, port 1 is read-only for the head entry. It presents valid/ready streaming interfaces to the producer and the consumer. Capacity is 2**DEPTH entries. There is no storage in this block except pointers, count and one valid flag.

---
 rtl/sync_fifo_ctrl_pkg.sv | 20 ++
 rtl/sync_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// ============================================================================
// sync_fifo_ctrl_pkg
// Shared types for the sync_mem FIFO pointer/handshake controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sync_fifo_ctrl_pkg;

  // {push_fire, pop_fire} decoded into the per-cycle occupancy operation.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// sync_fifo_ctrl
// Pointer, count and valid-flag controller that runs a 2-port sync_mem as a FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mem_writeEnable0,
  output logic [WIDTH-1:0] mem_writeData0,
  output logic [DEPTH-1:0] mem_address0,
  output logic             mem_writeEnable1,
  output logic [WIDTH-1:0] mem_writeData1,
  output logic [DEPTH-1:0] mem_address1,
  input  logic [WIDTH-1:0] mem_readData1,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int CAPACITY = 2 ** DEPTH;
  localparam logic [DEPTH:0] c_capacity = (DEPTH + 1)'(CAPACITY);

  logic [DEPTH-1:0] r_wr_ptr;
  logic [DEPTH-1:0] r_rd_ptr;
  logic [DEPTH:0]   r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_out_valid;

  logic             w_push_fire;
  logic             w_pop_fire;
  logic [DEPTH-1:0] w_rd_ptr_next;
  logic [DEPTH:0]   w_count_next;
  logic             w_out_valid_next;
  fifo_op_e         w_op;

  assign w_push_fire   = in_valid && !r_full;
  assign w_pop_fire    = r_out_valid && out_ready;
  assign w_rd_ptr_next = r_rd_ptr + DEPTH'(w_pop_fire);
  assign w_op          = fifo_op_e'({w_push_fire, w_pop_fire});

  always_comb begin
    w_count_next = r_count;
    case (w_op)
      OP_PUSH: w_count_next = r_count + (DEPTH + 1)'(1);
      OP_POP:  w_count_next = r_count - (DEPTH + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // sync_mem returns old data when the head slot is written at the same edge
  // it is read, so hold off valid for one cycle and re-read it afterwards.
  assign w_out_valid_next = (w_count_next != '0) &&
                            !(w_push_fire && (w_rd_ptr_next == r_wr_ptr));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + DEPTH'(1);
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == c_capacity);
      r_empty     <= (w_count_next == '0);
      r_out_valid <= w_out_valid_next;
    end
  end

  assign in_ready         = !r_full;
  assign out_valid        = r_out_valid;
  assign out_data         = mem_readData1;
  assign count            = r_count;
  assign full             = r_full;
  assign empty            = r_empty;

  assign mem_writeEnable0 = w_push_fire;
  assign mem_address0     = r_wr_ptr;
  assign mem_writeData0   = in_data;

  // Port 1 addresses the next head so readData1 is already current after a pop.
  assign mem_writeEnable1 = 1'b0;
  assign mem_writeData1   = '0;
  assign mem_address1     = w_rd_ptr_next;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// tb_sync_fifo_ctrl
// Directed bench for sync_fifo_ctrl driving a behavioural 2-port sync_mem.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             mem_writeEnable0;
  logic [WIDTH-1:0] mem_writeData0;
  logic [DEPTH-1:0] mem_address0;
  logic             mem_writeEnable1;
  logic [WIDTH-1:0] mem_writeData1;
  logic [DEPTH-1:0] mem_address1;
  logic [WIDTH-1:0] mem_readData1;
  logic [DEPTH:0]   count;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .mem_writeEnable0(mem_writeEnable0),
    .mem_writeData0  (mem_writeData0),
    .mem_address0    (mem_address0),
    .mem_writeEnable1(mem_writeEnable1),
    .mem_writeData1  (mem_writeData1),
    .mem_address1    (mem_address1),
    .mem_readData1   (mem_readData1),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  // Behavioural sync_mem: registered read, old data on same-address collision.
  logic [WIDTH-1:0] mem [0:(2**DEPTH)-1];
  always @(posedge clock) begin
    if (mem_writeEnable0) mem[mem_address0] <= mem_writeData0;
    if (mem_writeEnable1) mem[mem_address1] <= mem_writeData1;
    mem_readData1 <= mem[mem_address1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             ewe;
    logic             evalid;
    logic [WIDTH-1:0] edata;
    logic [DEPTH:0]   ecount;
    logic             efull;
    logic             eempty;
    logic             eready;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] stall_data;
    logic             stall_prev;
    int               sent;
    int               got;
    bit               seen;

    // rst iv id ordy | we valid data count full empty ready
    vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hA, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 4'h0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h7, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset/idle, single-word latency and the count=1 push+pop bubble.
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(mem_writeEnable0), 32'(vecs[i].ewe));
      tick();
      chk($sformatf("vec%0d_state", i), 32'({out_valid, count, full, empty, in_ready}),
          32'({vecs[i].evalid, vecs[i].ecount, vecs[i].efull, vecs[i].eempty, vecs[i].eready}));
      if (vecs[i].evalid) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].edata));
    end

    // Fill to capacity with the consumer stalled.
    reset = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      #1;
      chk($sformatf("fill_ready%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    chk("full_state", 32'({count, full, in_ready, out_valid}), 32'({5'd16, 1'b1, 1'b0, 1'b1}));
    in_data = 4'h5;
    #1;
    chk("push_when_full_we", 32'(mem_writeEnable0), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("push_when_full_pop_we", 32'(mem_writeEnable0), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("full_count_hold", 32'(count), 32'd16);

    // Drain: one word per cycle in order, no bubbles.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain_data%0d", i), 32'(out_data), 32'(i));
      tick();
    end
    chk("drain_end", 32'({empty, out_valid, count}), 32'({1'b1, 1'b0, 5'd0}));

    // Streaming across pointer wrap with a randomly stalling consumer.
    sent = 0; got = 0; stall_prev = 1'b0; stall_data = '0;
    for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
      in_valid  = (sent < 40);
      in_data   = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stream_pop_nonempty", 32'd0, 32'd1);
        else chk("stream_data", 32'(out_data), 32'(q.pop_front()));
        got++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      tick();
    end
    chk("stream_words", 32'(got), 32'd40);

    // Reset mid-operation discards resident words.
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("pre_reset", 32'({out_valid, count}), 32'({1'b1, 5'd5}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset", 32'({out_valid, count, empty, full, in_ready}),
        32'({1'b0, 5'd0, 1'b1, 1'b0, 1'b1}));
    in_valid = 1'b1; in_data = 4'hC; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) begin
        chk("first_after_reset", 32'(out_data), 32'hC);
        seen = 1'b1;
      end
      tick();
    end
    if (!seen) chk("first_after_reset_timeout", 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
